branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/core_pkg.sv | 18 +
 rtl/bht_counter_array.sv | 45 ++++
 rtl/branch_predictor.sv | 114 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: branch prediction modes
// and the resolved-branch update bundle.
package core_pkg;

  localparam int PRED_STATIC  = 0;
  localparam int PRED_BTB     = 1;
  localparam int PRED_BTB_BHT = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } upd_t;

endpackage

// File: rtl/bht_counter_array.sv
// Branch history table of saturating counters.
// Ports: clk/rst, combinational read (rd_idx -> rd_msb),
// synchronous update (wr_en, wr_idx, wr_taken).
module bht_counter_array
  import core_pkg::*;
#(
  parameter int BHT_ENTRIES = 256,
  parameter int CNT_WIDTH   = 2,
  parameter int IW          = $clog2(BHT_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_msb,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic          wr_taken
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT =
    CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt [BHT_ENTRIES];
  logic [CNT_WIDTH-1:0] cur;

  assign rd_msb = cnt[rd_idx][CNT_WIDTH-1];
  assign cur    = cnt[wr_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        cnt[i] <= CNT_INIT;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (cur != CNT_MAX)
          cnt[wr_idx] <= cur + 1'b1;
      end else begin
        if (cur != '0)
          cnt[wr_idx] <= cur - 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + BHT branch predictor with mispredict detect and stats.
// Ports: CPU_CLK/CPU_RST, IF lookup (pc_if_i -> pred_*), EX update (upd_*),
// redirect (mispredict_o, redirect_pc_o), stats (stat_branch_o, stat_miss_o).
module branch_predictor
  import core_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int BHT_ENTRIES = 256,
  parameter int CNT_WIDTH   = 2,
  parameter int PRED_MODE   = 2
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] pc_if_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] stat_branch_o,
  output logic [31:0] stat_miss_o
);

  localparam int BW = $clog2(BTB_ENTRIES);
  localparam int HW = $clog2(BHT_ENTRIES);
  localparam int TW = 30 - BW;

  upd_t upd;
  assign upd = '{
    valid:       upd_valid_i,
    pc:          upd_pc_i,
    taken:       upd_taken_i,
    target:      upd_target_i,
    pred_taken:  upd_pred_taken_i,
    pred_target: upd_pred_target_i
  };

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TW-1:0]          btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];

  logic [BW-1:0] rd_bidx;
  logic [BW-1:0] wr_bidx;
  logic          hit;
  logic          bht_msb;

  assign rd_bidx = pc_if_i[BW+1:2];
  assign wr_bidx = upd.pc[BW+1:2];
  assign hit     = btb_valid[rd_bidx] &&
                   (btb_tag[rd_bidx] == pc_if_i[31:BW+2]);

  bht_counter_array #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_bht (
    .clk      (CPU_CLK),
    .rst      (CPU_RST),
    .rd_idx   (pc_if_i[HW+1:2]),
    .rd_msb   (bht_msb),
    .wr_en    (upd.valid),
    .wr_idx   (upd.pc[HW+1:2]),
    .wr_taken (upd.taken)
  );

  always_comb begin
    pred_taken_o = 1'b0;
    case (PRED_MODE)
      PRED_BTB:     pred_taken_o = hit;
      PRED_BTB_BHT: pred_taken_o = hit & bht_msb;
      default:      pred_taken_o = 1'b0;
    endcase
  end

  assign pred_target_o = pred_taken_o ? btb_target[rd_bidx]
                                      : pc_if_i + 32'd4;

  // A taken/taken pair still mispredicts if the cached target was stale.
  assign mispredict_o = upd.valid &&
    ((upd.taken != upd.pred_taken) ||
     (upd.taken && upd.pred_taken &&
      (upd.target != upd.pred_target)));

  assign redirect_pc_o = upd.taken ? upd.target : upd.pc + 32'd4;

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST)
      btb_valid <= '0;
    else if (upd.valid && upd.taken)
      btb_valid[wr_bidx] <= 1'b1;
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST && upd.valid && upd.taken) begin
      btb_tag[wr_bidx]    <= upd.pc[31:BW+2];
      btb_target[wr_bidx] <= upd.target;
    end
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      stat_branch_o <= '0;
      stat_miss_o   <= '0;
    end else begin
      stat_branch_o <= stat_branch_o + {31'd0, upd.valid};
      stat_miss_o   <= stat_miss_o + {31'd0, mispredict_o};
    end
  end

endmodule
